// File: rtl/log_ctrl_pkg.sv
// Shared types for the sample-logging sequencer: FSM state encoding and read latency.
package log_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StLog     = 3'd1,
        StDone    = 3'd2,
        StRdIssue = 3'd3,
        StRdWait  = 3'd4
    } log_state_e;

    // Cycles from an accepted read request to o_rd_valid.
    localparam int unsigned LOG_RD_LATENCY = 3;

endpackage

// File: rtl/log_decim.sv
// Decimation counter for log_ctrl: passes every (decim_i+1)-th valid, starting with the first.
// Only instantiated when LOG_DECIM_EN is defined.
module log_decim (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clear_i,
    input  logic       en_i,
    input  logic       valid_i,
    input  logic [7:0] decim_i,
    output logic       valid_o
);

    logic [7:0] cnt_q, cnt_d;

    assign valid_o = en_i & valid_i & (cnt_q == 8'd0);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = 8'd0;
        end else if (en_i && valid_i) begin
            cnt_d = (cnt_q == decim_i) ? 8'd0 : cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/log_ctrl.sv
// Sample-logging RAM sequencer: captures valid samples into RAM, then serves single-word reads.
// Optional decimation of the sample stream is enabled by defining LOG_DECIM_EN.
module log_ctrl
    import log_ctrl_pkg::*;
#(
    parameter int unsigned RAM_DEPTH = 32768,
    parameter int unsigned NB_ADDR   = 15,
    parameter int unsigned RAM_WIDTH = 32
) (
    input  logic                 clock,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic                 i_abort,
    input  logic                 i_sample_valid,
    input  logic [RAM_WIDTH-1:0] i_sample,
    input  logic                 i_rd_req,
    input  logic [NB_ADDR-1:0]   i_rd_addr,
`ifdef LOG_DECIM_EN
    input  logic [7:0]           i_decim,
`endif
    output logic                 o_ram_we,
    output logic                 o_ram_re,
    output logic [NB_ADDR-1:0]   o_ram_addr,
    output logic [RAM_WIDTH-1:0] o_ram_wdata,
    input  logic [RAM_WIDTH-1:0] i_ram_rdata,
    output logic [RAM_WIDTH-1:0] o_rd_data,
    output logic                 o_rd_valid,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [NB_ADDR:0]     o_count,
    output logic [2:0]           o_state
);

    localparam logic [NB_ADDR:0] CountOne  = (NB_ADDR + 1)'(1);
    localparam logic [NB_ADDR:0] CountFull = (NB_ADDR + 1)'(RAM_DEPTH);

    log_state_e             state_q, state_d;
    logic [NB_ADDR:0]       count_q, count_d;
    logic                   we_q, we_d;
    logic                   re_q, re_d;
    logic [NB_ADDR-1:0]     addr_q, addr_d;
    logic [RAM_WIDTH-1:0]   wdata_q, wdata_d;
    logic [RAM_WIDTH-1:0]   rd_data_q, rd_data_d;
    logic                   rd_valid_q, rd_valid_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   start_d1_q;
    logic                   armed_q;
    logic                   start_edge;
    logic                   log_valid;

    // armed_q blocks the first cycle after reset so a start level held through release is no edge.
    assign start_edge = i_start & ~start_d1_q & armed_q;

`ifdef LOG_DECIM_EN
    logic decim_en;
    assign decim_en = (state_q == StLog) & ~i_abort;

    log_decim u_log_decim (
        .clk_i   (clock),
        .rst_ni  (i_reset),
        .clear_i (start_edge),
        .en_i    (decim_en),
        .valid_i (i_sample_valid),
        .decim_i (i_decim),
        .valid_o (log_valid)
    );
`else
    assign log_valid = i_sample_valid;
`endif

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        we_d       = 1'b0;
        re_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_edge && !i_abort) begin
                    state_d = StLog;
                    count_d = '0;
                end
            end
            StLog: begin
                // Abort wins over a coincident sample; that sample is dropped.
                if (i_abort) begin
                    state_d = StDone;
                end else if (log_valid) begin
                    we_d    = 1'b1;
                    addr_d  = count_q[NB_ADDR-1:0];
                    wdata_d = i_sample;
                    count_d = count_q + CountOne;
                    if (count_d == CountFull) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                if (start_edge && !i_abort) begin
                    state_d = StLog;
                    count_d = '0;
                end else if (i_rd_req) begin
                    state_d = StRdIssue;
                    re_d    = 1'b1;
                    addr_d  = i_rd_addr;
                end
            end
            StRdIssue: begin
                state_d = StRdWait;
            end
            StRdWait: begin
                rd_data_d  = i_ram_rdata;
                rd_valid_d = 1'b1;
                state_d    = StDone;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d == StLog);
        done_d = (state_d == StDone) || (state_d == StRdIssue) || (state_d == StRdWait);
    end

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= StIdle;
            count_q    <= '0;
            we_q       <= 1'b0;
            re_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            start_d1_q <= 1'b0;
            armed_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            we_q       <= we_d;
            re_q       <= re_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            start_d1_q <= i_start;
            armed_q    <= 1'b1;
        end
    end

    assign o_ram_we    = we_q;
    assign o_ram_re    = re_q;
    assign o_ram_addr  = addr_q;
    assign o_ram_wdata = wdata_q;
    assign o_rd_data   = rd_data_q;
    assign o_rd_valid  = rd_valid_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_count     = count_q;
    assign o_state     = state_q;

endmodule

// File: tb/tb_log_ctrl.sv
// Scoreboard bench for log_ctrl: expected RAM writes and read returns are queued by the
// stimulus and checked by a monitor whenever the DUT strobes o_ram_we or o_rd_valid.
module tb_log_ctrl;
    import log_ctrl_pkg::*;

    localparam int unsigned Depth = 128;
    localparam int unsigned Nb    = 7;
    localparam int unsigned Width = 32;

    logic             clock = 1'b0;
    logic             i_reset;
    logic             i_start, i_abort, i_sample_valid, i_rd_req;
    logic [Width-1:0] i_sample;
    logic [Nb-1:0]    i_rd_addr;
`ifdef LOG_DECIM_EN
    logic [7:0]       i_decim;
`endif
    logic             o_ram_we, o_ram_re, o_rd_valid, o_busy, o_done;
    logic [Nb-1:0]    o_ram_addr;
    logic [Width-1:0] o_ram_wdata, o_rd_data;
    logic [Width-1:0] i_ram_rdata;
    logic [Nb:0]      o_count;
    logic [2:0]       o_state;

    int checks = 0;
    int errors = 0;

    logic [Nb+Width-1:0] wr_q[$];
    logic [Width-1:0]    rd_q[$];
    logic [Width-1:0]    mem[Depth];

    always #5 clock = ~clock;

    log_ctrl #(
        .RAM_DEPTH (Depth),
        .NB_ADDR   (Nb),
        .RAM_WIDTH (Width)
    ) dut (
        .clock          (clock),
        .i_reset        (i_reset),
        .i_start        (i_start),
        .i_abort        (i_abort),
        .i_sample_valid (i_sample_valid),
        .i_sample       (i_sample),
        .i_rd_req       (i_rd_req),
        .i_rd_addr      (i_rd_addr),
`ifdef LOG_DECIM_EN
        .i_decim        (i_decim),
`endif
        .o_ram_we       (o_ram_we),
        .o_ram_re       (o_ram_re),
        .o_ram_addr     (o_ram_addr),
        .o_ram_wdata    (o_ram_wdata),
        .i_ram_rdata    (i_ram_rdata),
        .o_rd_data      (o_rd_data),
        .o_rd_valid     (o_rd_valid),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_count        (o_count),
        .o_state        (o_state)
    );

    // Single-port RAM model with one-cycle read latency; unwritten words hold 0xDEAD00xx.
    initial begin
        for (int i = 0; i < Depth; i++) mem[i] = 32'hDEAD_0000 | i;
        i_ram_rdata = '0;
    end
    always @(posedge clock) begin
        if (o_ram_we) mem[o_ram_addr] <= o_ram_wdata;
        if (o_ram_re) i_ram_rdata <= mem[o_ram_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops and compares on every DUT write or read return.
    always @(negedge clock) begin
        logic [Nb+Width-1:0] w;
        logic [Width-1:0]    r;
        check("we_re_exclusive", {31'd0, o_ram_we & o_ram_re}, 32'd0);
        if (o_ram_we) begin
            if (wr_q.size() == 0) begin
                check("unexpected_write_addr", {25'd0, o_ram_addr}, 32'hFFFF_FFFF);
            end else begin
                w = wr_q.pop_front();
                check("write_addr", {25'd0, o_ram_addr}, {25'd0, w[Nb+Width-1:Width]});
                check("write_data", o_ram_wdata, w[Width-1:0]);
            end
        end
        if (o_rd_valid) begin
            if (rd_q.size() == 0) begin
                check("unexpected_rd_valid", o_rd_data, 32'hFFFF_FFFF);
            end else begin
                r = rd_q.pop_front();
                check("rd_data", o_rd_data, r);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start_pulse();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic push_sample(input logic [Nb-1:0] addr, input logic [Width-1:0] data,
                               input bit expect_write);
        i_sample_valid = 1'b1;
        i_sample       = data;
        if (expect_write) wr_q.push_back({addr, data});
        tick();
        i_sample_valid = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_state"}, {29'd0, o_state}, 32'd0);
        check({tag, "_busy"}, {31'd0, o_busy}, 32'd0);
        check({tag, "_done"}, {31'd0, o_done}, 32'd0);
        check({tag, "_count"}, {24'd0, o_count}, 32'd0);
        check({tag, "_we"}, {31'd0, o_ram_we}, 32'd0);
        check({tag, "_re"}, {31'd0, o_ram_re}, 32'd0);
        check({tag, "_addr"}, {25'd0, o_ram_addr}, 32'd0);
        check({tag, "_wdata"}, o_ram_wdata, 32'd0);
        check({tag, "_rd_data"}, o_rd_data, 32'd0);
        check({tag, "_rd_valid"}, {31'd0, o_rd_valid}, 32'd0);
    endtask

    task automatic do_read(input logic [Nb-1:0] addr, input logic [Width-1:0] exp);
        i_rd_req  = 1'b1;
        i_rd_addr = addr;
        rd_q.push_back(exp);
        tick();
        i_rd_req = 1'b0;
        repeat (LOG_RD_LATENCY - 1) tick();
        check("read_rd_valid", {31'd0, o_rd_valid}, 32'd1);
        tick();
    endtask

    initial begin
        logic [Width-1:0] smp[6];
        smp[0] = 32'h0001_0002;
        smp[1] = 32'h0011_0012;
        smp[2] = 32'h0021_0022;
        smp[3] = 32'h00AB_00CD;
        smp[4] = 32'h0041_0042;
        smp[5] = 32'h0051_0052;

        i_reset = 1'b0;
        i_start = 1'b1;  // held high through reset release
        i_abort = 1'b0;
        i_sample_valid = 1'b0;
        i_sample = '0;
        i_rd_req = 1'b0;
        i_rd_addr = '0;
`ifdef LOG_DECIM_EN
        i_decim = 8'd0;
`endif
        repeat (3) tick();
        check_all_zero("reset");

        // Start level already high at release and a read request in IDLE: nothing happens.
        i_reset = 1'b1;
        repeat (3) tick();
        i_rd_req = 1'b1;
        tick();
        i_rd_req = 1'b0;
        repeat (4) tick();
        check("held_start_state", {29'd0, o_state}, 32'd0);
        check("held_start_busy", {31'd0, o_busy}, 32'd0);
        check("held_start_re", {31'd0, o_ram_re}, 32'd0);
        i_start = 1'b0;
        tick();

        // Five samples, then abort together with the sixth.
        start_pulse();
        check("start_busy", {31'd0, o_busy}, 32'd1);
        check("start_state", {29'd0, o_state}, 32'd1);
        for (int i = 0; i < 5; i++) push_sample(i[Nb-1:0], smp[i], 1'b1);
        i_abort = 1'b1;
        push_sample(7'd5, smp[5], 1'b0);
        i_abort = 1'b0;
        check("abort_count", {24'd0, o_count}, 32'd5);
        check("abort_state", {29'd0, o_state}, 32'd2);
        check("abort_done", {31'd0, o_done}, 32'd1);
        check("abort_busy", {31'd0, o_busy}, 32'd0);
        tick();

        // Read of address 3; a second request during RD_ISSUE must be ignored.
        i_rd_req  = 1'b1;
        i_rd_addr = 7'd3;
        rd_q.push_back(32'h00AB_00CD);
        tick();
        check("rd_issue_re", {31'd0, o_ram_re}, 32'd1);
        check("rd_issue_addr", {25'd0, o_ram_addr}, 32'd3);
        check("rd_issue_state", {29'd0, o_state}, 32'd3);
        i_rd_addr = 7'd5;
        tick();
        i_rd_req = 1'b0;
        check("rd_wait_state", {29'd0, o_state}, 32'd4);
        check("rd_wait_re", {31'd0, o_ram_re}, 32'd0);
        check("rd_wait_valid", {31'd0, o_rd_valid}, 32'd0);
        tick();
        check("rd_ret_valid", {31'd0, o_rd_valid}, 32'd1);
        check("rd_ret_data", o_rd_data, 32'h00AB_00CD);
        check("rd_ret_state", {29'd0, o_state}, 32'd2);
        tick();
        check("rd_pulse_end", {31'd0, o_rd_valid}, 32'd0);
        check("rd_data_held", o_rd_data, 32'h00AB_00CD);
        repeat (3) tick();
        check("rd_second_ignored_state", {29'd0, o_state}, 32'd2);

        // Address above o_count returns stale RAM content.
        do_read(7'd9, 32'hDEAD_0009);
        do_read(7'd0, 32'h0001_0002);

        // Async reset mid-capture at o_count=100, then restart from address 0.
        start_pulse();
        for (int i = 0; i < 100; i++) push_sample(i[Nb-1:0], 32'h1000_0000 + i, 1'b1);
        tick();
        check("mid_count", {24'd0, o_count}, 32'd100);
        #2;
        i_reset = 1'b0;
        #1;
        check_all_zero("async_reset");
        tick();
        i_reset = 1'b1;
        tick();
        start_pulse();
        push_sample(7'd0, 32'h3000_0000, 1'b1);
        check("restart_addr", {25'd0, o_ram_addr}, 32'd0);
        check("restart_count", {24'd0, o_count}, 32'd1);
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;

        // Full capture: Depth+4 consecutive valids, only Depth are written.
        start_pulse();
        for (int i = 0; i < Depth + 4; i++) begin
            i_sample_valid = 1'b1;
            i_sample = 32'h2000_0000 + i;
            if (i < Depth) wr_q.push_back({i[Nb-1:0], 32'h2000_0000 + i});
            tick();
            if (i == Depth - 2) check("full_done_early", {31'd0, o_done}, 32'd0);
            if (i == Depth - 1) begin
                check("full_done_last", {31'd0, o_done}, 32'd1);
                check("full_we_last", {31'd0, o_ram_we}, 32'd1);
                check("full_addr_last", {25'd0, o_ram_addr}, Depth - 1);
            end
        end
        i_sample_valid = 1'b0;
        tick();
        check("full_count", {24'd0, o_count}, Depth);
        check("full_state", {29'd0, o_state}, 32'd2);
        do_read(7'd127, 32'h2000_007F);

`ifdef LOG_DECIM_EN
        // Decimation by 3: samples 1, 4 and 7 of nine are written.
        i_decim = 8'd2;
        start_pulse();
        for (int i = 1; i <= 9; i++) begin
            push_sample(7'((i - 1) / 3), 32'h4000_0000 + i, (i % 3) == 1);
        end
        tick();
        check("decim_count", {24'd0, o_count}, 32'd3);
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
`endif

        repeat (3) tick();
        check("write_queue_empty", wr_q.size(), 32'd0);
        check("read_queue_empty", rd_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
